// File: rtl/lcd_bf_reader_if.sv
// lcd_bf_reader_if: handshake and LCD bus signals of the busy-flag reader
interface lcd_bf_reader_if;
    logic       req;
    logic       poll;
    logic [7:0] DB_in;
    logic       ready;
    logic       done;
    logic       bf;
    logic [6:0] addr;
    logic       timeout;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       DB_oe;
    modport master (
        output req, poll, DB_in,
        input  ready, done, bf, addr, timeout, LCD_E, LCD_RS, LCD_RW, DB_oe
    );
    modport slave (
        input  req, poll, DB_in,
        output ready, done, bf, addr, timeout, LCD_E, LCD_RS, LCD_RW, DB_oe
    );
endinterface

// File: rtl/lcd_bf_reader.sv
// lcd_bf_reader: HD44780 instruction-read (BF/AC) controller with optional BF polling; LCD_BF_TIMEOUT_EN adds a poll limit
module lcd_bf_reader #(
    parameter int T_AS      = 2,
    parameter int T_EH      = 12,
    parameter int T_EL      = 13,
    parameter int MAX_POLLS = 1024
) (
    input logic            clk,
    input logic            rst,
    lcd_bf_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, E_LOW, DONE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       poll_r;
    logic       again;

    assign bus.LCD_RS = 1'b0;

`ifdef LCD_BF_TIMEOUT_EN
    logic [15:0] pcnt;
    assign again = poll_r && bus.bf && pcnt != 16'(MAX_POLLS - 1);
`else
    logic unused_max;
    assign unused_max  = ^16'(MAX_POLLS);
    assign again       = poll_r && bus.bf;
    assign bus.timeout = 1'b0;
`endif

    // Phase sequencer: setup, E pulse, E recovery, done pulse; all bus outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            poll_r     <= 1'b0;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
            bus.bf     <= 1'b0;
            bus.addr   <= '0;
            bus.LCD_E  <= 1'b0;
            bus.LCD_RW <= 1'b0;
            bus.DB_oe  <= 1'b1;
`ifdef LCD_BF_TIMEOUT_EN
            pcnt        <= '0;
            bus.timeout <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.req) begin
                    state      <= SETUP;
                    poll_r     <= bus.poll;
                    cnt        <= '0;
                    bus.ready  <= 1'b0;
                    bus.LCD_RW <= 1'b1;
                    bus.DB_oe  <= 1'b0;
`ifdef LCD_BF_TIMEOUT_EN
                    pcnt        <= '0;
                    bus.timeout <= 1'b0;
`endif
                end
                SETUP: if (cnt == 8'(T_AS - 1)) begin
                    cnt       <= '0;
                    state     <= E_HIGH;
                    bus.LCD_E <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                E_HIGH: if (cnt == 8'(T_EH - 1)) begin
                    cnt       <= '0;
                    state     <= E_LOW;
                    bus.LCD_E <= 1'b0;
                    bus.bf    <= bus.DB_in[7];
                    bus.addr  <= bus.DB_in[6:0];
                end else begin
                    cnt <= cnt + 8'd1;
                end
                E_LOW: if (cnt == 8'(T_EL - 1)) begin
                    cnt <= '0;
                    if (again) begin
                        state <= SETUP;
`ifdef LCD_BF_TIMEOUT_EN
                        pcnt <= pcnt + 16'd1;
`endif
                    end else begin
                        state      <= DONE;
                        bus.done   <= 1'b1;
                        bus.LCD_RW <= 1'b0;
`ifdef LCD_BF_TIMEOUT_EN
                        bus.timeout <= poll_r && bus.bf;
`endif
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DONE: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                    bus.DB_oe <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lcd_bf_reader.md
# lcd_bf_reader

Read-side controller for the character LCD parallel bus. It performs HD44780 instruction reads (RS=0, RW=1) to fetch the busy flag (BF) and address counter (AC), and optionally polls until BF clears. It sits beside the write datapath that drives DB_out. It owns LCD_E/LCD_RS/LCD_RW and the DB output-enable while a read is in progress, so the top-level FSM can replace fixed delays with BF polling.

## Interface
- T_AS, 2: cycles RS/RW are stable before LCD_E rises (1..255)
- T_EH, 12: cycles LCD_E is high (1..255)
- T_EL, 13: cycles LCD_E is low after a pulse before the next phase (1..255)
- MAX_POLLS, 1024: poll iterations before timeout; used only with LCD_BF_TIMEOUT_EN (1..65535)
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req  input  1  start a read; accepted only when ready=1
- poll  input  1  sampled with req; 1 = repeat reads until BF=0
- DB_in  input  8  LCD data bus as read from the pad
- ready  output  1  idle and able to accept req
- done  output  1  one-cycle pulse when the operation finishes
- bf  output  1  last captured DB_in[7]
- addr  output  7  last captured DB_in[6:0]
- timeout  output  1  set with done when polling was aborted
- LCD_E  output  1  LCD enable strobe
- LCD_RS  output  1  register select, always 0 from this block
- LCD_RW  output  1  1 during a read
- DB_oe  output  1  1 = write datapath may drive DB, 0 = bus released

## Operation
- All outputs are registered.
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE.
- IDLE:
  - ready=1, DB_oe=1, LCD_RW=0, LCD_E=0.
  - On req=1, latch poll into poll_r, clear the poll counter, and go to SETUP.
- SETUP:
  - Lasts T_AS cycles with LCD_RW=1, DB_oe=0, LCD_E=0.
  - Then go to E_HIGH.
- E_HIGH:
  - Lasts T_EH cycles with LCD_E=1.
  - At the edge ending the last E_HIGH cycle, capture bf<=DB_in[7] and addr<=DB_in[6:0]; LCD_E falls at that same edge.
- E_LOW:
  - Lasts T_EL cycles with LCD_E=0, LCD_RW=1, DB_oe=0.
  - Exit: if poll_r=1 and bf=1 (and no timeout), increment the poll counter and go to SETUP. Otherwise go to DONE.
- DONE:
  - One cycle: done=1, LCD_RW=0, DB_oe=0, ready=0.
  - Then go to IDLE, where DB_oe returns to 1.
  - Keeping DB_oe=0 for this cycle guarantees one cycle of no drive after RW falls.
- req is ignored whenever ready=0, including during DONE.
- poll is sampled only at acceptance.
- Phase counter is 8 bits; poll counter is 16 bits.

## Timing
- Reset values (asynchronous, immediate, including mid-read): state=IDLE, ready=1, done=0, bf=0, addr=0, timeout=0, LCD_E=0, LCD_RS=0, LCD_RW=0, DB_oe=1.
- A reset during E_HIGH forces LCD_E low without waiting for a clock edge.
- Single read: with req accepted at edge k, done is high in the cycle starting at edge k+T_AS+T_EH+T_EL (defaults: k+27).
- Each extra poll iteration adds T_AS+T_EH+T_EL cycles.
- ready is high again in the cycle after done, so back-to-back requests are possible at a 1-cycle gap.
- LCD_RW is stable for T_AS cycles before LCD_E rises and for T_EL cycles after it falls.

## Configuration
- LCD_BF_TIMEOUT_EN defined:
  - The poll counter is compared against MAX_POLLS.
  - When poll_r=1, bf=1 and the counter equals MAX_POLLS-1 at E_LOW exit, go to DONE with timeout=1 for the done cycle.
  - timeout clears on the next accepted req.
- LCD_BF_TIMEOUT_EN undefined:
  - No poll counter is built and timeout is tied to 0.
  - Polling continues indefinitely until BF=0 or reset.

## Test plan
- Reset, then check idle values: ready=1, DB_oe=1, LCD_E=0, LCD_RW=0, bf=0, addr=0.
- Single read: req=1, poll=0, DB_in=8'h85 (defaults) -> LCD_RW=1 and DB_oe=0 from the accept edge, LCD_E high exactly 12 cycles starting 2 cycles after accept, done at accept+27, bf=1, addr=7'h05, ready=1 the following cycle.
- Poll: poll=1, DB_in=8'h80 for the first 3 reads then 8'h12 -> 4 E pulses, done at accept+4*27, bf=0, addr=7'h12, timeout=0.
- Timeout (LCD_BF_TIMEOUT_EN, MAX_POLLS=4): DB_in=8'hFF constant -> exactly 4 E pulses, then done=1 with timeout=1.
- req held high through DONE -> second read starts exactly 1 cycle after the done pulse; no req is accepted while ready=0.
- rst asserted mid E_HIGH -> LCD_E, LCD_RW=0 and DB_oe=1 asynchronously; no done pulse; after release a new req runs a normal 27-cycle read.
